// File: rtl/cdb_pkg.sv
// Shared types and constants for the common-data-bus arbiter and its age selector.
// Purely declarative: no logic, no latency, no flow control.
package cdb_pkg;

  localparam int NUM_REQ   = 4;
  localparam int ROB_IDX_W = 4;
  localparam int DATA_W    = 32;

  localparam int FU_ALU = 0;
  localparam int FU_MUL = 1;
  localparam int FU_DIV = 2;
  localparam int FU_LSU = 3;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [DATA_W-1:0]    data;
  } cdb_req_t;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [DATA_W-1:0]    data;
  } cdb_bcast_t;

  // Distance from the ROB head; smaller means older, wrap-around is natural.
  function automatic logic [ROB_IDX_W-1:0] rob_age(input logic [ROB_IDX_W-1:0] idx,
                                                   input logic [ROB_IDX_W-1:0] head);
    return idx - head;
  endfunction

endpackage

// File: rtl/age_select.sv
// Combinational oldest-first selector: ages relative to the ROB head, flush kill mask, min-age tree.
// Zero latency; produces a one-hot grant among surviving requests, ties go to the lower index.
module age_select #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_IDX_W = 4
) (
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][ROB_IDX_W-1:0] req_rob_idx,
  input  logic [ROB_IDX_W-1:0]              rob_head,
  input  logic                              flush,
  input  logic [ROB_IDX_W-1:0]              flush_rob_idx,
  output logic [NUM_REQ-1:0]                grant,
  output logic [NUM_REQ-1:0]                kill
);

  localparam int LVL    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LEAVES = 1 << LVL;
  localparam int NODES  = 2 * LEAVES - 1;

  logic [NUM_REQ-1:0][ROB_IDX_W-1:0] w_age;
  logic [ROB_IDX_W-1:0]              w_flush_age;
  logic [NUM_REQ-1:0]                w_live;

  logic                 w_nd_vld [NODES];
  logic [ROB_IDX_W-1:0] w_nd_age [NODES];
  logic [LVL-1:0]       w_nd_idx [NODES];

  always_comb begin
    w_flush_age = flush_rob_idx - rob_head;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_age[i]  = req_rob_idx[i] - rob_head;
      // The branch itself (equal age) survives; only younger results die.
      kill[i]   = req_valid[i] && flush && (w_age[i] > w_flush_age);
      w_live[i] = req_valid[i] && !kill[i];
    end
  end

  // Heap-ordered tree: leaf i sits at LEAVES-1+i, so left subtrees hold lower indices.
  always_comb begin
    for (int n = 0; n < NODES; n++) begin
      w_nd_vld[n] = 1'b0;
      w_nd_age[n] = '0;
      w_nd_idx[n] = '0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      w_nd_vld[LEAVES-1+i] = w_live[i];
      w_nd_age[LEAVES-1+i] = w_age[i];
      w_nd_idx[LEAVES-1+i] = LVL'(i);
    end
    for (int n = LEAVES - 2; n >= 0; n--) begin
      if (w_nd_vld[2*n+1] &&
          (!w_nd_vld[2*n+2] || (w_nd_age[2*n+1] <= w_nd_age[2*n+2]))) begin
        w_nd_vld[n] = 1'b1;
        w_nd_age[n] = w_nd_age[2*n+1];
        w_nd_idx[n] = w_nd_idx[2*n+1];
      end else begin
        w_nd_vld[n] = w_nd_vld[2*n+2];
        w_nd_age[n] = w_nd_age[2*n+2];
        w_nd_idx[n] = w_nd_idx[2*n+2];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (w_nd_vld[0]) grant[w_nd_idx[0]] = 1'b1;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants the oldest surviving FU result each cycle and broadcasts it one cycle later.
// req_ready is combinational (grant or flush kill); the broadcast side never backpressures.
module cdb_arbiter #(
  parameter int NUM_REQ   = cdb_pkg::NUM_REQ,
  parameter int ROB_IDX_W = cdb_pkg::ROB_IDX_W,
  parameter int DATA_W    = cdb_pkg::DATA_W
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][ROB_IDX_W-1:0] req_rob_idx,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [ROB_IDX_W-1:0]              rob_head,
  input  logic                              flush,
  input  logic [ROB_IDX_W-1:0]              flush_rob_idx,
  output logic                              cdb_valid,
  output logic [ROB_IDX_W-1:0]              cdb_rob_idx,
  output logic [DATA_W-1:0]                 cdb_data,
  output logic [31:0]                       cdb_bcast_cnt
);

  import cdb_pkg::*;

  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_kill;
  cdb_bcast_t         w_sel;
  cdb_bcast_t         r_bcast;
  logic [31:0]        r_cnt;

  age_select #(
    .NUM_REQ   (NUM_REQ),
    .ROB_IDX_W (ROB_IDX_W)
  ) u_age_select (
    .req_valid     (req_valid),
    .req_rob_idx   (req_rob_idx),
    .rob_head      (rob_head),
    .flush         (flush),
    .flush_rob_idx (flush_rob_idx),
    .grant         (w_grant),
    .kill          (w_kill)
  );

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel.valid   = 1'b1;
        w_sel.rob_idx = w_sel.rob_idx | req_rob_idx[i];
        w_sel.data    = w_sel.data | req_data[i];
      end
    end
  end

  // Gated by reset so requesters keep holding across an asynchronous reset.
  assign req_ready = (w_grant | w_kill) & {NUM_REQ{reset}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bcast <= '0;
      r_cnt   <= '0;
    end else begin
      r_bcast.valid <= w_sel.valid;
      if (w_sel.valid) begin
        r_bcast.rob_idx <= w_sel.rob_idx;
        r_bcast.data    <= w_sel.data;
      end
      if (r_bcast.valid && (r_cnt != '1)) r_cnt <= r_cnt + 32'd1;
    end
  end

  assign cdb_valid     = r_bcast.valid;
  assign cdb_rob_idx   = r_bcast.rob_idx;
  assign cdb_data      = r_bcast.data;
  assign cdb_bcast_cnt = r_cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios then random traffic against an age-ranking reference model.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int RW = 4;
  localparam int DW = 32;

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0]        req_valid;
  logic [N-1:0][RW-1:0] req_rob_idx;
  logic [N-1:0][DW-1:0] req_data;
  logic [N-1:0]        req_ready;
  logic [RW-1:0]       rob_head;
  logic                flush;
  logic [RW-1:0]       flush_rob_idx;
  logic                cdb_valid;
  logic [RW-1:0]       cdb_rob_idx;
  logic [DW-1:0]       cdb_data;
  logic [31:0]         cdb_bcast_cnt;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(N), .ROB_IDX_W(RW), .DATA_W(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_rob_idx   (req_rob_idx),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .rob_head      (rob_head),
    .flush         (flush),
    .flush_rob_idx (flush_rob_idx),
    .cdb_valid     (cdb_valid),
    .cdb_rob_idx   (cdb_rob_idx),
    .cdb_data      (cdb_data),
    .cdb_bcast_cnt (cdb_bcast_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Requester state: each FU holds one pending result until it is consumed.
  bit          p_vld [N];
  int          p_idx [N];
  logic [31:0] p_dat [N];
  int          head  = 0;
  bit          fl    = 0;
  int          fidx  = 0;

  // Reference broadcast register and counter.
  bit          m_vld = 0;
  int          m_idx = 0;
  logic [31:0] m_dat = '0;
  longint      m_cnt = 0;

  function automatic int age(input int idx, input int h);
    return (idx - h + 16) % 16;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]   = p_vld[i];
      req_rob_idx[i] = RW'(p_idx[i]);
      req_data[i]    = p_dat[i];
    end
    rob_head      = RW'(head);
    flush         = fl;
    flush_rob_idx = RW'(fidx);
  endtask

  task automatic set_req(input int fu, input int idx, input logic [31:0] dat);
    p_vld[fu] = 1'b1;
    p_idx[fu] = idx;
    p_dat[fu] = dat;
  endtask

  // One clock: predict ready, check it mid-cycle, then check the registered broadcast.
  task automatic cycle();
    logic [3:0] er;
    int best, bage, fage, a;
    drive();
    er = '0;
    best = -1;
    bage = 0;
    if (reset) begin
      fage = age(fidx, head);
      for (int i = 0; i < N; i++) begin
        if (p_vld[i]) begin
          a = age(p_idx[i], head);
          if (fl && a > fage) er[i] = 1'b1;
          else if (best < 0 || a < bage) begin
            best = i;
            bage = a;
          end
        end
      end
      if (best >= 0) er[best] = 1'b1;
    end
    @(negedge clk);
    chk("req_ready", 64'(req_ready), 64'(er));
    @(posedge clk);
    if (reset) begin
      if (m_vld && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      m_vld = (best >= 0);
      if (best >= 0) begin
        m_idx = p_idx[best];
        m_dat = p_dat[best];
      end
    end
    #1;
    chk("cdb_valid", 64'(cdb_valid), 64'(m_vld));
    chk("cdb_rob_idx", 64'(cdb_rob_idx), 64'(m_idx));
    chk("cdb_data", 64'(cdb_data), 64'(m_dat));
    chk("cdb_bcast_cnt", 64'(cdb_bcast_cnt), 64'(m_cnt));
    for (int i = 0; i < N; i++) if (er[i]) p_vld[i] = 1'b0;
  endtask

  function automatic bit idx_live(input int idx);
    for (int i = 0; i < N; i++) if (p_vld[i] && p_idx[i] == idx) return 1'b1;
    return 1'b0;
  endfunction

  int seq [3];
  int nxt;

  initial begin
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, i, 32'h100 + 32'(i));

    // Reset holds everything quiet even with all requests raised.
    cycle();
    cycle();
    for (int i = 0; i < N; i++) p_vld[i] = 1'b0;
    reset = 1'b1;

    // Single ALU request.
    head = 3;
    set_req(cdb_pkg::FU_ALU, 5, 32'd42);
    cycle();
    cycle();
    chk("single_cnt", 64'(cdb_bcast_cnt), 64'd1);

    // Wrap-around ordering with head near the top.
    head = 14;
    set_req(cdb_pkg::FU_MUL, 15, 32'hA15);
    set_req(cdb_pkg::FU_ALU, 0, 32'hA00);
    set_req(cdb_pkg::FU_DIV, 1, 32'hA01);
    seq[0] = 15; seq[1] = 0; seq[2] = 1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("wrap_seq", 64'(cdb_rob_idx), 64'(seq[k]));
    end
    cycle();

    // Flush kills the younger LSU result, the older ALU result broadcasts.
    head = 0; fl = 1'b1; fidx = 2;
    set_req(cdb_pkg::FU_LSU, 3, 32'd7);
    set_req(cdb_pkg::FU_ALU, 1, 32'd9);
    cycle();
    fl = 1'b0;
    chk("flush_bcast_idx", 64'(cdb_rob_idx), 64'd1);
    chk("flush_bcast_data", 64'(cdb_data), 64'd9);
    cycle();

    // The mispredicted branch itself survives its own flush.
    fl = 1'b1; fidx = 4;
    set_req(cdb_pkg::FU_DIV, 4, 32'h55);
    set_req(cdb_pkg::FU_MUL, 6, 32'h66);
    cycle();
    fl = 1'b0;
    chk("branch_kept", 64'(cdb_rob_idx), 64'd4);
    cycle();

    // Continuous MUL/DIV traffic, then an asynchronous reset mid-cycle.
    head = 5;
    nxt = 6;
    for (int c = 0; c < 4; c++) begin
      for (int fu = 1; fu <= 2; fu++) begin
        if (!p_vld[fu]) begin
          set_req(fu, nxt, 32'hB000 + 32'(nxt));
          nxt = (nxt + 1) % 16;
        end
      end
      cycle();
    end
    for (int fu = 1; fu <= 2; fu++) begin
      if (!p_vld[fu]) begin
        set_req(fu, nxt, 32'hB000 + 32'(nxt));
        nxt = (nxt + 1) % 16;
      end
    end
    drive();
    #2;
    reset = 1'b0;
    #1;
    m_vld = 0; m_idx = 0; m_dat = '0; m_cnt = 0;
    chk("async_rst_valid", 64'(cdb_valid), 64'd0);
    chk("async_rst_ready", 64'(req_ready), 64'd0);
    chk("async_rst_cnt", 64'(cdb_bcast_cnt), 64'd0);
    cycle();
    reset = 1'b1;
    cycle();
    cycle();
    cycle();

    // Random traffic: moving head, occasional flushes, unique live ROB indices.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) head = $urandom_range(15);
      fl = ($urandom_range(7) == 0);
      fidx = $urandom_range(15);
      for (int fu = 0; fu < N; fu++) begin
        if (!p_vld[fu] && $urandom_range(1) == 1) begin
          int cand;
          cand = $urandom_range(15);
          while (idx_live(cand)) cand = (cand + 1) % 16;
          set_req(fu, cand, $urandom);
        end
      end
      cycle();
    end
    fl = 1'b0;
    for (int fu = 0; fu < N; fu++) p_vld[fu] = 1'b0;
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common data bus (CDB) arbiter for the out-of-order core. It shares the single result-writeback bus among the functional units (ALU, MUL, DIV, LSU). Each cycle it grants the oldest pending result, measured relative to the ROB head, and discards results squashed by a branch-mispredict flush. The granted result is registered and broadcast to the ROB and the reservation stations.

## Interface
Parameters:
- NUM_REQ, 4, number of requesting functional units (index 0 = ALU, 1 = MUL, 2 = DIV, 3 = LSU)
- ROB_IDX_W, 4, ROB index width (ROB depth 2^ROB_IDX_W)
- DATA_W, 32, result width

Ports:
- clk  input  1  core clock
- reset  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQ  per-FU result pending
- req_rob_idx  input  NUM_REQ x ROB_IDX_W  destination ROB entry per FU
- req_data  input  NUM_REQ x DATA_W  result value per FU
- req_ready  output  NUM_REQ  result consumed this cycle (granted or killed)
- rob_head  input  ROB_IDX_W  index of the oldest ROB entry
- flush  input  1  mispredict flush this cycle
- flush_rob_idx  input  ROB_IDX_W  ROB index of the mispredicted branch
- cdb_valid  output  1  broadcast valid
- cdb_rob_idx  output  ROB_IDX_W  broadcast ROB tag
- cdb_data  output  DATA_W  broadcast value
- cdb_bcast_cnt  output  32  saturating count of broadcasts since reset

## Operation
- **Handshake.** A requester holds valid, idx and data stable until req_ready is high. A transfer occurs on valid && ready. A requester must never assert valid with a ROB index equal to another live request.
- **Age computation.** age_i = (req_rob_idx[i] − rob_head) mod 2^ROB_IDX_W, unsigned, ROB_IDX_W bits, with natural wrap-around. Smaller age means older.
- **Kill on flush.** When flush=1, flush_age = (flush_rob_idx − rob_head) mod 2^ROB_IDX_W. Each valid request with age_i > flush_age is killed:
  - req_ready[i]=1 that cycle;
  - the request is never broadcast.
  - A request with age == flush_age (the branch itself) survives.
- **Selection.** Among valid, non-killed requests, the one with minimum age is granted (req_ready=1). Ties cannot occur legally; if one does, the lower requester index wins.
  - At most one grant per cycle.
  - Killed requesters and the granted requester may all see ready in the same cycle.
- **Output stage.** The grant is loaded into the output register: cdb_valid=1 with its idx and data. If there is no grant, cdb_valid=0 and cdb_rob_idx/cdb_data hold their previous values.
- **Already-registered entry.** An entry already in the output register when flush arrives is still broadcast; the ROB filters it.
- **Broadcast counter.** cdb_bcast_cnt increments on every cycle with cdb_valid=1 and saturates at 2^32−1.
- **No backpressure.** The ROB and reservation stations always accept a broadcast.

## Timing
- **Reset values.** While reset=0: cdb_valid=0, cdb_rob_idx=0, cdb_data=0, cdb_bcast_cnt=0, req_ready=0. These take effect immediately (asynchronous reset), including mid-operation; pending requests are not lost because requesters keep holding them.
- **Grant path.** req_ready is combinational from req_valid, req_rob_idx, rob_head, flush and flush_rob_idx in the same cycle T.
- **Latency.** Broadcast appears on cdb_* in cycle T+1, one cycle after the grant.
- **Throughput.** One broadcast per cycle. Back-to-back grants produce continuous cdb_valid.
- **Wrap-around.** The ROB index wraps at 2^ROB_IDX_W. Age arithmetic must handle the head near the top of the index range, e.g. head=14 ranks idx 15 before 0 before 1.
- **Flush and head movement together.** rob_head may change in the same cycle as flush. The ages for that cycle use the current rob_head value.

## Structure
- **Shared package cdb_pkg:**
  - cdb_req_t struct {valid, rob_idx, data};
  - cdb_bcast_t struct {valid, rob_idx, data};
  - ROB_IDX_W/DATA_W localparams;
  - requester index constants FU_ALU=0, FU_MUL=1, FU_DIV=2, FU_LSU=3.
- **Sub-module age_select:** combinational age computation, kill mask and min-age tree producing a one-hot grant plus the kill mask. cdb_arbiter adds the output register and the counter around it.

## Test plan
1. **Reset.** Hold reset=0 with all req_valid=1 → cdb_valid=0, req_ready=4'b0000, cdb_bcast_cnt=0.
2. **Single request.** rob_head=3, ALU request idx 5, data 42 → req_ready[0]=1 in cycle T; cycle T+1 shows cdb_valid=1, cdb_rob_idx=5, cdb_data=42, and the counter then reads 1.
3. **Wrap ordering.** rob_head=14; MUL idx 15, ALU idx 0 and DIV idx 1 asserted simultaneously and held → broadcasts 15, 0, 1 on three consecutive cycles, then cdb_valid=0.
4. **Flush kill.** rob_head=0, flush=1, flush_rob_idx=2; LSU idx 3 (data 7) and ALU idx 1 (data 9) → both ready that cycle; next cycle broadcasts only idx 1 / 9. Idx 3 is never broadcast.
5. **Flush keeps the branch.** flush_rob_idx=4, request idx 4 → granted and broadcast.
6. **Reset mid-stream.** Continuous requests from MUL and DIV for 4 cycles, then reset=0 mid-cycle → cdb_valid drops to 0 immediately with no clock edge. After release, the held requests are granted oldest-first.
